// File: rtl/csr_trap_unit_if.sv
// Execute-stage CSR/trap bus between the pipeline and csr_trap_unit.
// The pipeline side is the master and the trap unit is the slave.
interface csr_trap_unit_if;
  logic        Stall;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        control;
  logic [31:0] epc;
  logic        flush;

  modport master (
    output Stall, instr_valid, instr_pc, csr_addr, csr_op, csr_wdata,
           is_mret, timer_irq, ext_irq,
    input  csr_rdata, control, epc, flush
  );

  modport slave (
    input  Stall, instr_valid, instr_pc, csr_addr, csr_op, csr_wdata,
           is_mret, timer_irq, ext_irq,
    output csr_rdata, control, epc, flush
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: interrupt entry, mret and CSR
// instruction writes, driving the PC redirect (control/epc) and flush.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  csr_trap_unit_if.slave  bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0880;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  // Registers keep full 32-bit width with unimplemented bits held at zero
  // by masking on write; synthesis prunes the constant bits.
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q,     mie_d;
  logic [31:0] mip_q,     mip_d;
  logic [31:0] mtvec_q,   mtvec_d;
  logic [31:0] mepc_q,    mepc_d;
  logic [31:0] mcause_q,  mcause_d;

  logic [31:0] rdata;
  logic [31:0] wval;
  logic        go;
  logic        irq;
  logic        do_mret;
  logic        do_csr;

  always_comb begin
    rdata = '0;
    unique case (bus.csr_addr)
      ADDR_MSTATUS: rdata = mstatus_q | MSTATUS_MPP;
      ADDR_MIE:     rdata = mie_q;
      ADDR_MIP:     rdata = mip_q;
      ADDR_MTVEC:   rdata = mtvec_q;
      ADDR_MEPC:    rdata = mepc_q;
      ADDR_MCAUSE:  rdata = mcause_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    unique case (bus.csr_op)
      2'b01:   wval = bus.csr_wdata;
      2'b10:   wval = rdata | bus.csr_wdata;
      2'b11:   wval = rdata & ~bus.csr_wdata;
      default: wval = rdata;
    endcase
  end

  assign go      = bus.instr_valid & ~bus.Stall;
  assign irq     = mstatus_q[3] & (|(mip_q & mie_q)) & go;
  assign do_mret = bus.is_mret & go & ~irq;
  assign do_csr  = (bus.csr_op != 2'b00) & go & ~irq;

  always_comb begin
    mstatus_d = mstatus_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mip_d     = '0;
    mip_d[7]  = bus.timer_irq;
    mip_d[11] = bus.ext_irq;

    if (irq) begin
      mepc_d    = bus.instr_pc & ALIGN_MASK;
      mcause_d  = (mip_q[11] & mie_q[11]) ? CAUSE_EXT : CAUSE_TIMER;
      mstatus_d = {24'b0, mstatus_q[3], 7'b0};
    end else if (do_mret) begin
      mstatus_d = {24'b0, 1'b1, 3'b0, mstatus_q[7], 3'b0};
    end

    if (do_csr) begin
      unique case (bus.csr_addr)
        ADDR_MSTATUS: mstatus_d = wval & MSTATUS_MASK;
        ADDR_MIE:     mie_d     = wval & MIE_MASK;
        ADDR_MTVEC:   mtvec_d   = wval & ALIGN_MASK;
        ADDR_MEPC:    mepc_d    = wval & ALIGN_MASK;
        ADDR_MCAUSE:  mcause_d  = wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mip_q     <= '0;
      mtvec_q   <= MTVEC_RST & ALIGN_MASK;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mie_q     <= mie_d;
      mip_q     <= mip_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Reset masks the redirect so a trap decided in the reset cycle never
  // reaches the program counter.
  assign bus.control   = (irq | do_mret) & ~reset;
  assign bus.flush     = bus.control;
  assign bus.epc       = do_mret ? mepc_q : mtvec_q;
  assign bus.csr_rdata = rdata;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: reset state, CSR ops, traps, mret,
// interrupt priority, stall hold-off and reset over a pending trap.
module tb_csr_trap_unit;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_OTHER   = 12'h123;
  localparam logic [31:0] RST_VEC   = 32'h0000_0200;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] d;

  csr_trap_unit_if bus ();

  csr_trap_unit #(.MTVEC_RST(RST_VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Stall       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_pc    = '0;
    bus.csr_addr    = '0;
    bus.csr_op      = 2'b00;
    bus.csr_wdata   = '0;
    bus.is_mret     = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] v);
    bus.csr_addr = a;
    #1;
    v = bus.csr_rdata;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
    bus.instr_valid = 1'b1;
    bus.csr_op      = op;
    bus.csr_addr    = a;
    bus.csr_wdata   = w;
    step();
    idle();
  endtask

  task automatic test_reset();
    tests++; if (bus.control !== 1'b0) begin fails++; $display("FAIL reset_control got %b exp 0", bus.control); end
    tests++; if (bus.epc !== RST_VEC) begin fails++; $display("FAIL reset_epc got %h exp %h", bus.epc, RST_VEC); end
    peek(A_MSTATUS, d); tests++; if (d !== 32'h0000_1800) begin fails++; $display("FAIL reset_mstatus got %h exp 00001800", d); end
    peek(A_MIE, d);     tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mie got %h exp 0", d); end
    peek(A_MIP, d);     tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mip got %h exp 0", d); end
    peek(A_MTVEC, d);   tests++; if (d !== RST_VEC) begin fails++; $display("FAIL reset_mtvec got %h exp %h", d, RST_VEC); end
    peek(A_MEPC, d);    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mepc got %h exp 0", d); end
    peek(A_MCAUSE, d);  tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mcause got %h exp 0", d); end
    peek(A_OTHER, d);   tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_other got %h exp 0", d); end
  endtask

  task automatic test_csr_ops();
    csr_do(2'b01, A_MCAUSE, 32'h0000_00F0);
    csr_do(2'b10, A_MCAUSE, 32'h0000_000F);
    bus.instr_valid = 1'b1; bus.csr_op = 2'b11; bus.csr_addr = A_MCAUSE; bus.csr_wdata = 32'h0000_003C;
    #1;
    tests++; if (bus.csr_rdata !== 32'h0000_00FF) begin fails++; $display("FAIL csr_old_value got %h exp 000000ff", bus.csr_rdata); end
    step(); idle();
    peek(A_MCAUSE, d); tests++; if (d !== 32'h0000_00C3) begin fails++; $display("FAIL csr_clear got %h exp 000000c3", d); end
    csr_do(2'b01, A_MEPC, 32'h0000_0123);
    peek(A_MEPC, d); tests++; if (d !== 32'h0000_0120) begin fails++; $display("FAIL mepc_align got %h exp 00000120", d); end
    csr_do(2'b01, A_MIP, 32'hFFFF_FFFF);
    peek(A_MIP, d); tests++; if (d !== 32'h0) begin fails++; $display("FAIL mip_readonly got %h exp 0", d); end
    csr_do(2'b01, A_OTHER, 32'hDEAD_BEEF);
    peek(A_OTHER, d); tests++; if (d !== 32'h0) begin fails++; $display("FAIL other_write got %h exp 0", d); end
    csr_do(2'b01, A_MSTATUS, 32'hFFFF_FFFF);
    peek(A_MSTATUS, d); tests++; if (d !== 32'h0000_1888) begin fails++; $display("FAIL mstatus_mask got %h exp 00001888", d); end
    csr_do(2'b01, A_MSTATUS, 32'h0);
  endtask

  task automatic test_timer_trap();
    bus.instr_valid = 1'b1; bus.csr_op = 2'b01; bus.csr_addr = A_MTVEC; bus.csr_wdata = 32'h0000_0100;
    #1;
    tests++; if (bus.csr_rdata !== RST_VEC) begin fails++; $display("FAIL mtvec_old got %h exp %h", bus.csr_rdata, RST_VEC); end
    step(); idle();
    csr_do(2'b10, A_MIE, 32'h0000_0080);
    csr_do(2'b10, A_MSTATUS, 32'h0000_0008);
    bus.timer_irq = 1'b1; bus.instr_valid = 1'b1; bus.instr_pc = 32'h40;
    #1;
    tests++; if (bus.control !== 1'b0) begin fails++; $display("FAIL irq_latency got %b exp 0", bus.control); end
    step();
    tests++; if (bus.control !== 1'b1 || bus.flush !== 1'b1) begin fails++; $display("FAIL trap_control got %b/%b exp 1/1", bus.control, bus.flush); end
    tests++; if (bus.epc !== 32'h100) begin fails++; $display("FAIL trap_epc got %h exp 00000100", bus.epc); end
    step();
    tests++; if (bus.control !== 1'b0) begin fails++; $display("FAIL back_to_back got %b exp 0", bus.control); end
    bus.timer_irq = 1'b0; idle();
    step();
    peek(A_MEPC, d);    tests++; if (d !== 32'h40) begin fails++; $display("FAIL trap_mepc got %h exp 00000040", d); end
    peek(A_MCAUSE, d);  tests++; if (d !== 32'h8000_0007) begin fails++; $display("FAIL trap_mcause got %h exp 80000007", d); end
    peek(A_MSTATUS, d); tests++; if (d !== 32'h0000_1880) begin fails++; $display("FAIL trap_mstatus got %h exp 00001880", d); end
  endtask

  task automatic test_mret();
    bus.instr_valid = 1'b1; bus.is_mret = 1'b1; bus.instr_pc = 32'h44;
    #1;
    tests++; if (bus.control !== 1'b1) begin fails++; $display("FAIL mret_control got %b exp 1", bus.control); end
    tests++; if (bus.epc !== 32'h40) begin fails++; $display("FAIL mret_epc got %h exp 00000040", bus.epc); end
    step(); idle();
    peek(A_MSTATUS, d); tests++; if (d !== 32'h0000_1888) begin fails++; $display("FAIL mret_mstatus got %h exp 00001888", d); end
  endtask

  task automatic test_ext_priority();
    csr_do(2'b01, A_MIE, 32'h0000_0880);
    bus.timer_irq = 1'b1; bus.ext_irq = 1'b1;
    step();
    peek(A_MIP, d); tests++; if (d !== 32'h0000_0880) begin fails++; $display("FAIL mip_pending got %h exp 00000880", d); end
    tests++; if (bus.control !== 1'b0) begin fails++; $display("FAIL bubble_control got %b exp 0", bus.control); end
    bus.instr_valid = 1'b1; bus.instr_pc = 32'h80;
    #1;
    tests++; if (bus.control !== 1'b1) begin fails++; $display("FAIL ext_control got %b exp 1", bus.control); end
    step(); idle();
    bus.timer_irq = 1'b0; bus.ext_irq = 1'b0;
    step();
    peek(A_MCAUSE, d); tests++; if (d !== 32'h8000_000B) begin fails++; $display("FAIL ext_mcause got %h exp 8000000b", d); end
    peek(A_MEPC, d);   tests++; if (d !== 32'h80) begin fails++; $display("FAIL ext_mepc got %h exp 00000080", d); end
  endtask

  task automatic test_stall();
    bus.instr_valid = 1'b1; bus.is_mret = 1'b1; bus.instr_pc = 32'h84;
    step(); idle();
    bus.timer_irq = 1'b1;
    step();
    bus.Stall = 1'b1; bus.instr_valid = 1'b1; bus.instr_pc = 32'hC0; bus.csr_addr = A_MEPC;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.control !== 1'b0) begin fails++; $display("FAIL stall_control cycle %0d got %b exp 0", i, bus.control); end
      tests++; if (bus.csr_rdata !== 32'h80) begin fails++; $display("FAIL stall_mepc cycle %0d got %h exp 00000080", i, bus.csr_rdata); end
      step();
    end
    bus.Stall = 1'b0;
    #1;
    tests++; if (bus.control !== 1'b1 || bus.epc !== 32'h100) begin fails++; $display("FAIL unstall_trap got %b/%h exp 1/00000100", bus.control, bus.epc); end
    step(); idle();
    bus.timer_irq = 1'b0;
    step();
    peek(A_MEPC, d);   tests++; if (d !== 32'hC0) begin fails++; $display("FAIL unstall_mepc got %h exp 000000c0", d); end
    peek(A_MCAUSE, d); tests++; if (d !== 32'h8000_0007) begin fails++; $display("FAIL unstall_mcause got %h exp 80000007", d); end
  endtask

  task automatic test_reset_pending();
    bus.timer_irq = 1'b1;
    bus.instr_valid = 1'b1; bus.is_mret = 1'b1; bus.instr_pc = 32'hC4;
    step(); idle();
    reset = 1'b1; bus.instr_valid = 1'b1; bus.instr_pc = 32'hC8;
    #1;
    tests++; if (bus.control !== 1'b0 || bus.flush !== 1'b0) begin fails++; $display("FAIL reset_trap_control got %b/%b exp 0/0", bus.control, bus.flush); end
    step();
    reset = 1'b0; idle(); bus.timer_irq = 1'b0;
    tests++; if (bus.epc !== RST_VEC) begin fails++; $display("FAIL rst2_epc got %h exp %h", bus.epc, RST_VEC); end
    peek(A_MSTATUS, d); tests++; if (d !== 32'h0000_1800) begin fails++; $display("FAIL rst2_mstatus got %h exp 00001800", d); end
    peek(A_MIE, d);     tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst2_mie got %h exp 0", d); end
    peek(A_MIP, d);     tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst2_mip got %h exp 0", d); end
    peek(A_MTVEC, d);   tests++; if (d !== RST_VEC) begin fails++; $display("FAIL rst2_mtvec got %h exp %h", d, RST_VEC); end
    peek(A_MEPC, d);    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst2_mepc got %h exp 0", d); end
    peek(A_MCAUSE, d);  tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst2_mcause got %h exp 0", d); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.timer_irq = 1'b0;
    bus.ext_irq   = 1'b0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_csr_ops();
    test_timer_trap();
    test_mret();
    test_ext_priority();
    test_stall();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
